level_manager: RTL and testbench

- Game-progress controller that owns the current level number and feeds `level` to the level display block and the game logic.
- Advances the level on a level-cleared event and inserts a frame-timed transition pause between levels.
- Flags game-won after the last level and holds state on game over.
- Drives a blink gate that the top level ANDs with the level display's draw signal during transitions.

---
 rtl/level_manager.sv | 141 ++++++++++++++
 tb/tb_level_manager.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/level_manager.sv
// Level progression controller: owns the level number, inserts a frame-timed pause between levels,
// and flags won/over. Define LEVEL_BLINK_EN to blink the level display during the pause.
module level_manager #(
    parameter int FIRST_LEVEL       = 1,
    parameter int MAX_LEVEL         = 9,
    parameter int TRANSITION_FRAMES = 120,
    parameter int BLINK_FRAMES      = 15
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       newGame,
    input  logic       levelCleared,
    input  logic       gameOver,
    output logic [3:0] level,
    output logic       levelTransition,
    output logic       showLevel,
    output logic       gameWon
);

    if (FIRST_LEVEL < 1 || FIRST_LEVEL > MAX_LEVEL || MAX_LEVEL > 15 ||
        TRANSITION_FRAMES < 1 || TRANSITION_FRAMES > 255 ||
        BLINK_FRAMES < 1 || BLINK_FRAMES > 255) begin : g_param_check
        $error("level_manager: parameter out of range");
    end

    localparam logic [3:0] FIRST_LVL  = 4'(FIRST_LEVEL);
    localparam logic [3:0] MAX_LVL    = 4'(MAX_LEVEL);
    localparam logic [7:0] LAST_FRAME = 8'(TRANSITION_FRAMES - 1);

    typedef enum logic [2:0] {IDLE, PLAY, TRANSITION, WON, OVER} state_t;

    state_t     state_q, state_d;
    logic [3:0] level_q, level_d;
    logic [7:0] frameCnt_q, frameCnt_d;
    logic       gameWon_q, gameWon_d;
    logic       showLevel_q, showLevel_d;
    logic       trans_q;

`ifdef LEVEL_BLINK_EN
    localparam logic [7:0] LAST_BLINK = 8'(BLINK_FRAMES - 1);
    logic [7:0] blinkCnt_q, blinkCnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        frameCnt_d  = frameCnt_q;
        gameWon_d   = gameWon_q;
        // Display is shown everywhere except while a blink phase is running in TRANSITION.
        showLevel_d = 1'b1;
`ifdef LEVEL_BLINK_EN
        blinkCnt_d  = 8'd0;
`endif
        if (newGame) begin
            state_d    = TRANSITION;
            level_d    = FIRST_LVL;
            gameWon_d  = 1'b0;
            frameCnt_d = 8'd0;
        end else begin
            case (state_q)
                PLAY: begin
                    if (gameOver) begin
                        state_d = OVER;
                    end else if (levelCleared) begin
                        if (level_q < MAX_LVL) begin
                            level_d    = level_q + 4'd1;
                            frameCnt_d = 8'd0;
                            state_d    = TRANSITION;
                        end else begin
                            gameWon_d = 1'b1;
                            state_d   = WON;
                        end
                    end
                end
                TRANSITION: begin
                    if (gameOver) begin
                        state_d    = OVER;
                        frameCnt_d = 8'd0;
                    end else begin
`ifdef LEVEL_BLINK_EN
                        blinkCnt_d  = blinkCnt_q;
                        showLevel_d = showLevel_q;
`endif
                        if (startOfFrame) begin
                            if (frameCnt_q == LAST_FRAME) begin
                                state_d     = PLAY;
                                frameCnt_d  = 8'd0;
`ifdef LEVEL_BLINK_EN
                                blinkCnt_d  = 8'd0;
                                showLevel_d = 1'b1;
`endif
                            end else begin
                                frameCnt_d = frameCnt_q + 8'd1;
`ifdef LEVEL_BLINK_EN
                                if (blinkCnt_q == LAST_BLINK) begin
                                    blinkCnt_d  = 8'd0;
                                    showLevel_d = ~showLevel_q;
                                end else begin
                                    blinkCnt_d = blinkCnt_q + 8'd1;
                                end
`endif
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            level_q     <= FIRST_LVL;
            frameCnt_q  <= 8'd0;
            gameWon_q   <= 1'b0;
            showLevel_q <= 1'b1;
            trans_q     <= 1'b0;
`ifdef LEVEL_BLINK_EN
            blinkCnt_q  <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            frameCnt_q  <= frameCnt_d;
            gameWon_q   <= gameWon_d;
            showLevel_q <= showLevel_d;
            trans_q     <= (state_d == TRANSITION);
`ifdef LEVEL_BLINK_EN
            blinkCnt_q  <= blinkCnt_d;
`endif
        end
    end

    assign level           = level_q;
    assign levelTransition = trans_q;
    assign showLevel       = showLevel_q;
    assign gameWon         = gameWon_q;

endmodule

// File: tb/tb_level_manager.sv
// Scoreboard bench for level_manager: a phase-level reference model pushes expected outputs,
// a monitor pops and compares them after every clock edge.
`timescale 1ns/1ps
module tb_level_manager;
    localparam int FIRST_LEVEL = 1;
    localparam int MAX_LEVEL   = 9;
    localparam int TF          = 120;
    localparam int BF          = 15;
    localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_WON = 3, M_OVER = 4;
`ifdef LEVEL_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       sof = 1'b0, ng = 1'b0, lc = 1'b0, go = 1'b0;
    logic [3:0] level;
    logic       levelTransition, showLevel, gameWon;

    level_manager #(
        .FIRST_LEVEL(FIRST_LEVEL), .MAX_LEVEL(MAX_LEVEL),
        .TRANSITION_FRAMES(TF), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .newGame(ng),
        .levelCleared(lc), .gameOver(go), .level(level),
        .levelTransition(levelTransition), .showLevel(showLevel), .gameWon(gameWon)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] level;
        logic       trans;
        logic       show;
        logic       won;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: game phase, level number, and frames elapsed in the current pause.
    int m_mode, m_level, m_frames;
    bit m_won;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode = M_IDLE; m_level = FIRST_LEVEL; m_frames = 0; m_won = 1'b0;
    endfunction

    function automatic void model_step(input bit n, input bit l, input bit g, input bit s);
        if (n) begin
            m_mode = M_PAUSE; m_level = FIRST_LEVEL; m_won = 1'b0; m_frames = 0;
        end else if (m_mode == M_PLAY) begin
            if (g) m_mode = M_OVER;
            else if (l) begin
                if (m_level == MAX_LEVEL) begin
                    m_won = 1'b1; m_mode = M_WON;
                end else begin
                    m_level++; m_mode = M_PAUSE; m_frames = 0;
                end
            end
        end else if (m_mode == M_PAUSE) begin
            if (g) m_mode = M_OVER;
            else if (s) begin
                m_frames++;
                if (m_frames == TF) m_mode = M_PLAY;
            end
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.level = 4'(m_level);
        e.trans = (m_mode == M_PAUSE);
        e.show  = (BLINK && m_mode == M_PAUSE) ? (((m_frames / BF) % 2) == 0) : 1'b1;
        e.won   = m_won;
        return e;
    endfunction

    task automatic step(input bit n, input bit l, input bit g, input bit s);
        @(negedge clk);
        ng = n; lc = l; go = g; sof = s;
        model_step(n, l, g, s);
        expq.push_back(model_out());
    endtask

    task automatic clear_level();
        step(0, 1, 0, 0);
        repeat (TF) step(0, 0, 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_level"}, int'(level), FIRST_LEVEL);
        check({tag, "_trans"}, int'(levelTransition), 0);
        check({tag, "_show"}, int'(showLevel), 1);
        check({tag, "_won"}, int'(gameWon), 0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            check("level", int'(level), int'(e.level));
            check("levelTransition", int'(levelTransition), int'(e.trans));
            check("showLevel", int'(showLevel), int'(e.show));
            check("gameWon", int'(gameWon), int'(e.won));
        end
    end

    initial begin
        bit n, l, s, go_l;
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        resetN = 1'b1;

        // Idle: only newGame leaves IDLE
        step(0, 0, 0, 0);
        step(0, 1, 0, 1);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        // Intro pause, sparse frame pulses
        step(1, 0, 0, 0);
        repeat (TF) begin
            step(0, 0, 0, 1);
            step(0, 0, 0, 0);
        end
        step(0, 0, 0, 0);

        // Up to level 3, then clear with coincident frame pulse and clears during the pause
        clear_level();
        clear_level();
        step(0, 1, 0, 1);
        step(0, 1, 0, 0);
        repeat (10) step(0, 0, 0, 1);
        step(0, 1, 0, 1);
        repeat (TF - 11) step(0, 0, 0, 1);

        // Through to the last level and win
        repeat (MAX_LEVEL - 4) clear_level();
        step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        step(0, 0, 1, 1);
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);

        // Game over mid-pause at frame 50, then newGame+gameOver together
        repeat (50) step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        repeat (3) step(0, 1, 0, 1);
        step(1, 0, 1, 0);
        step(0, 0, 0, 0);
        repeat (TF) step(0, 0, 0, 1);

        // Reach a pause at level 5, then asynchronous reset between edges
        repeat (3) clear_level();
        step(0, 1, 0, 0);
        repeat (37) step(0, 0, 0, 1);
        @(negedge clk);
        ng = 0; lc = 0; go = 0; sof = 0;
        #2 resetN = 1'b0;
        #1 check_reset_outputs("async_reset");
        model_reset();
        @(negedge clk);
        resetN = 1'b1;

        // Randomized play
        go_l = 1'b0;
        step(1, 0, 0, 0);
        repeat (15000) begin
            n = ($urandom_range(0, 2999) == 0);
            l = ($urandom_range(0, 29) == 0);
            s = ($urandom_range(0, 1) == 1);
            if (go_l) begin
                if ($urandom_range(0, 39) == 0) go_l = 1'b0;
            end else if ($urandom_range(0, 599) == 0) begin
                go_l = 1'b1;
            end
            if ($urandom_range(0, 999) == 0) begin
                n = 1'b1;
                go_l = 1'b0;
            end
            step(n, l, go_l, s);
        end
        step(0, 0, 0, 0);
        @(posedge clk);
        #3;
        check("scoreboard_drained", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
